// File: rtl/friscv_h.sv
// Shared FRISCV definitions: master index encoding used by the caches,
// the top level and the read arbiter.
package friscv_h;

  typedef enum logic {
    MST_ICACHE = 1'b0,
    MST_DCACHE = 1'b1
  } mst_idx_t;

endpackage

// File: rtl/friscv_scfifo.sv
// Single-clock FIFO with occupancy counter; pop on empty and push on full
// (without a simultaneous pop) are ignored.
module friscv_scfifo #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4
) (
  input  logic                       aclk,
  input  logic                       srst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           data_in,
  input  logic                       pop,
  output logic [WIDTH-1:0]           data_out,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign full     = (count == DEPTH[CNT_W-1:0]);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign data_out = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap by plain overflow
  always_ff @(posedge aclk) begin
    if (srst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge aclk) begin
    if (do_push) mem[wr_ptr] <= data_in;
  end

endmodule

// File: rtl/friscv_axi_rd_arbiter.sv
// Two-master AXI read arbiter: round-robin AR grant into a registered s_ar
// stage, in-order R routing driven by a FIFO of granted master indexes.
module friscv_axi_rd_arbiter
  import friscv_h::*;
#(
  parameter int AXI_ADDR_W  = 32,
  parameter int AXI_ID_W    = 8,
  parameter int AXI_DATA_W  = 128,
  parameter int OSTDREQ_NUM = 4
) (
  input  logic                  aclk,
  input  logic                  srst,
  input  logic                  m0_arvalid,
  output logic                  m0_arready,
  input  logic [AXI_ADDR_W-1:0] m0_araddr,
  input  logic [7:0]            m0_arlen,
  input  logic [AXI_ID_W-1:0]   m0_arid,
  output logic                  m0_rvalid,
  input  logic                  m0_rready,
  output logic [AXI_ID_W-1:0]   m0_rid,
  output logic [1:0]            m0_rresp,
  output logic [AXI_DATA_W-1:0] m0_rdata,
  output logic                  m0_rlast,
  input  logic                  m1_arvalid,
  output logic                  m1_arready,
  input  logic [AXI_ADDR_W-1:0] m1_araddr,
  input  logic [7:0]            m1_arlen,
  input  logic [AXI_ID_W-1:0]   m1_arid,
  output logic                  m1_rvalid,
  input  logic                  m1_rready,
  output logic [AXI_ID_W-1:0]   m1_rid,
  output logic [1:0]            m1_rresp,
  output logic [AXI_DATA_W-1:0] m1_rdata,
  output logic                  m1_rlast,
  output logic                  s_arvalid,
  input  logic                  s_arready,
  output logic [AXI_ADDR_W-1:0] s_araddr,
  output logic [7:0]            s_arlen,
  output logic [AXI_ID_W-1:0]   s_arid,
  input  logic                  s_rvalid,
  output logic                  s_rready,
  input  logic [AXI_ID_W-1:0]   s_rid,
  input  logic [1:0]            s_rresp,
  input  logic [AXI_DATA_W-1:0] s_rdata,
  input  logic                  s_rlast,
  output logic                  stray_r
);

  localparam int CNT_W = $clog2(OSTDREQ_NUM) + 1;

  mst_idx_t         prio;
  mst_idx_t         ar_mst;
  mst_idx_t         gnt_mst;
  mst_idx_t         head_mst;
  logic             gnt_vld;
  logic             s_ar_hs;
  logic             r_pop;
  logic             fifo_empty;
  logic [0:0]       head_bit;
  logic [CNT_W-1:0] fifo_cnt;
  logic [CNT_W:0]   pending;

  assign s_ar_hs  = s_arvalid && s_arready;
  assign head_mst = mst_idx_t'(head_bit);

  // The held s_ar entry counts toward the limit; a same-cycle pop is not
  // credited, so the grant after a full stall comes one cycle after the pop.
  assign pending = {1'b0, fifo_cnt} + (CNT_W+1)'(s_arvalid);

  always_comb begin
    gnt_vld = 1'b0;
    gnt_mst = prio;
    if (!srst && (!s_arvalid || s_arready) && (pending < OSTDREQ_NUM[CNT_W:0])) begin
      if (m0_arvalid && m1_arvalid) begin
        gnt_vld = 1'b1;
        gnt_mst = prio;
      end else if (m0_arvalid) begin
        gnt_vld = 1'b1;
        gnt_mst = MST_ICACHE;
      end else if (m1_arvalid) begin
        gnt_vld = 1'b1;
        gnt_mst = MST_DCACHE;
      end
    end
  end

  assign m0_arready = gnt_vld && (gnt_mst == MST_ICACHE);
  assign m1_arready = gnt_vld && (gnt_mst == MST_DCACHE);

  always_ff @(posedge aclk) begin
    if (srst) begin
      s_arvalid <= 1'b0;
      s_araddr  <= '0;
      s_arlen   <= '0;
      s_arid    <= '0;
      ar_mst    <= MST_ICACHE;
      prio      <= MST_ICACHE;
    end else begin
      if (s_ar_hs) prio <= (prio == MST_ICACHE) ? MST_DCACHE : MST_ICACHE;
      if (gnt_vld) begin
        s_arvalid <= 1'b1;
        ar_mst    <= gnt_mst;
        if (gnt_mst == MST_ICACHE) begin
          s_araddr <= m0_araddr;
          s_arlen  <= m0_arlen;
          s_arid   <= m0_arid;
        end else begin
          s_araddr <= m1_araddr;
          s_arlen  <= m1_arlen;
          s_arid   <= m1_arid;
        end
      end else if (s_ar_hs) begin
        s_arvalid <= 1'b0;
      end
    end
  end

  friscv_scfifo #(
    .WIDTH (1),
    .DEPTH (OSTDREQ_NUM)
  ) u_order_fifo (
    .aclk     (aclk),
    .srst     (srst),
    .push     (s_ar_hs),
    .data_in  (1'(ar_mst)),
    .pop      (r_pop),
    .data_out (head_bit),
    .empty    (fifo_empty),
    .count    (fifo_cnt)
  );

  always_comb begin
    m0_rvalid = 1'b0;
    m1_rvalid = 1'b0;
    s_rready  = 1'b1;
    stray_r   = 1'b0;
    if (fifo_empty) begin
      stray_r = s_rvalid;
    end else if (head_mst == MST_ICACHE) begin
      m0_rvalid = s_rvalid;
      s_rready  = m0_rready;
    end else begin
      m1_rvalid = s_rvalid;
      s_rready  = m1_rready;
    end
  end

  assign r_pop = s_rvalid && s_rready && s_rlast && !fifo_empty;

  assign m0_rid   = s_rid;
  assign m0_rresp = s_rresp;
  assign m0_rdata = s_rdata;
  assign m0_rlast = s_rlast;
  assign m1_rid   = s_rid;
  assign m1_rresp = s_rresp;
  assign m1_rdata = s_rdata;
  assign m1_rlast = s_rlast;

endmodule
